// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler: holds a decoded instruction until data, FU3 occupancy and
// writeback-slot hazards clear. Optional stall counter is enabled by defining ISSUE_STALL_CNT_EN.
module issue_scheduler #(
  parameter int unsigned LAT0     = 1,
  parameter int unsigned LAT1     = 3,
  parameter int unsigned LAT2     = 2,
  parameter int unsigned LAT3     = 5,
  parameter int unsigned WB_DEPTH = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  in_rs_i,
  input  logic [4:0]  in_rt_i,
  input  logic [4:0]  in_rd_i,
  input  logic        in_wr_i,
  input  logic [1:0]  in_fu_i,
  input  logic [31:0] pnd_sgn_i,
  output logic        sb_wre_o,
  output logic [4:0]  sb_reg_addr_o,
  output logic [1:0]  sb_func_uni_o,
  output logic        issue_valid_o,
  output logic [1:0]  issue_fu_o,
  output logic [4:0]  issue_rs_o,
  output logic [4:0]  issue_rt_o,
  output logic [4:0]  issue_rd_o,
  output logic [1:0]  stall_cause_o,
  output logic [15:0] stall_cnt_o
);

  localparam int unsigned LatW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  localparam logic [1:0] CauseNone = 2'd0;
  localparam logic [1:0] CauseData = 2'd1;
  localparam logic [1:0] CauseFu   = 2'd2;
  localparam logic [1:0] CauseWb   = 2'd3;

  logic [WB_DEPTH-1:0] wb_resv_q, wb_resv_d, wb_set;
  logic [LatW-1:0]     fu3_cnt_q, fu3_cnt_d;
  logic [LatW-1:0]     lat_sel;
  logic                issue_valid_q;
  logic [1:0]          issue_fu_q;
  logic [4:0]          issue_rs_q, issue_rt_q, issue_rd_q;
  logic [1:0]          stall_cause_q, stall_cause_d;
  logic                raw, waw, fu_busy, wb_busy, issue, stalled;

  always_comb begin
    case (in_fu_i)
      2'd0:    lat_sel = LatW'(LAT0);
      2'd1:    lat_sel = LatW'(LAT1);
      2'd2:    lat_sel = LatW'(LAT2);
      default: lat_sel = LatW'(LAT3);
    endcase
  end

  assign raw = ((in_rs_i != 5'd0) && pnd_sgn_i[in_rs_i]) ||
               ((in_rt_i != 5'd0) && pnd_sgn_i[in_rt_i]);
  assign waw = in_wr_i && (in_rd_i != 5'd0) && pnd_sgn_i[in_rd_i];
  assign fu_busy = (in_fu_i == 2'd3) && (fu3_cnt_q != '0);
  // Bit k means the bus is taken k cycles from now, so the probe uses the full latency.
  assign wb_busy = in_wr_i && wb_resv_q[lat_sel];

  assign in_ready_o = !reset_i && !raw && !waw && !fu_busy && !wb_busy;
  assign issue      = in_valid_i && in_ready_o;
  assign stalled    = in_valid_i && !in_ready_o;

  assign sb_wre_o      = !(issue && in_wr_i && (in_rd_i != 5'd0));
  assign sb_reg_addr_o = in_rd_i;
  assign sb_func_uni_o = in_fu_i;

  always_comb begin
    wb_set = '0;
    // Set one below the latency: the register already reflects next cycle's shifted view.
    if (issue && in_wr_i) wb_set[lat_sel - LatW'(1)] = 1'b1;
    wb_resv_d = (wb_resv_q >> 1) | wb_set;
  end

  always_comb begin
    fu3_cnt_d = fu3_cnt_q;
    if (issue && (in_fu_i == 2'd3)) fu3_cnt_d = LatW'(LAT3 - 1);
    else if (fu3_cnt_q != '0)       fu3_cnt_d = fu3_cnt_q - LatW'(1);
  end

  always_comb begin
    stall_cause_d = CauseNone;
    if (stalled) begin
      if (raw || waw)   stall_cause_d = CauseData;
      else if (fu_busy) stall_cause_d = CauseFu;
      else if (wb_busy) stall_cause_d = CauseWb;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wb_resv_q     <= '0;
      fu3_cnt_q     <= '0;
      issue_valid_q <= 1'b0;
      issue_fu_q    <= '0;
      issue_rs_q    <= '0;
      issue_rt_q    <= '0;
      issue_rd_q    <= '0;
      stall_cause_q <= CauseNone;
    end else begin
      wb_resv_q     <= wb_resv_d;
      fu3_cnt_q     <= fu3_cnt_d;
      issue_valid_q <= issue;
      stall_cause_q <= stall_cause_d;
      if (issue) begin
        issue_fu_q <= in_fu_i;
        issue_rs_q <= in_rs_i;
        issue_rt_q <= in_rt_i;
        issue_rd_q <= in_rd_i;
      end
    end
  end

  // Registered outputs are forced quiet for the whole reset window, including its first cycle.
  assign issue_valid_o = issue_valid_q && !reset_i;
  assign issue_fu_o    = reset_i ? 2'd0 : issue_fu_q;
  assign issue_rs_o    = reset_i ? 5'd0 : issue_rs_q;
  assign issue_rt_o    = reset_i ? 5'd0 : issue_rt_q;
  assign issue_rd_o    = reset_i ? 5'd0 : issue_rd_q;
  assign stall_cause_o = reset_i ? CauseNone : stall_cause_q;

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else if (stalled && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: issued instructions queue their expected FU packet and a
// negedge monitor checks each issue_valid pulse against the queue.
module tb_issue_scheduler;

  logic        clock, reset;
  logic        in_valid, in_ready, in_wr;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [1:0]  in_fu;
  logic [31:0] pnd_sgn;
  logic        sb_wre;
  logic [4:0]  sb_reg_addr;
  logic [1:0]  sb_func_uni;
  logic        issue_valid;
  logic [1:0]  issue_fu;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic [1:0]  stall_cause;
  logic [15:0] stall_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [1:0]  prev_cause = 2'd0;
  logic [16:0] exp_q[$];

  issue_scheduler dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_rs_i       (in_rs),
    .in_rt_i       (in_rt),
    .in_rd_i       (in_rd),
    .in_wr_i       (in_wr),
    .in_fu_i       (in_fu),
    .pnd_sgn_i     (pnd_sgn),
    .sb_wre_o      (sb_wre),
    .sb_reg_addr_o (sb_reg_addr),
    .sb_func_uni_o (sb_func_uni),
    .issue_valid_o (issue_valid),
    .issue_fu_o    (issue_fu),
    .issue_rs_o    (issue_rs),
    .issue_rt_o    (issue_rt),
    .issue_rd_o    (issue_rd),
    .stall_cause_o (stall_cause),
    .stall_cnt_o   (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && issue_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL issue_unexpected: got fu=%0d rd=%0d expected no issue at %0t",
                 issue_fu, issue_rd, $time);
      end else begin
        check("issue_packet", {15'd0, issue_fu, issue_rs, issue_rt, issue_rd},
              {15'd0, exp_q.pop_front()});
      end
    end
  end

  // One cycle: drive after posedge, check combinational and registered outputs at negedge.
  task automatic step(input logic rst, input logic v, input logic [1:0] fu,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic wr, input logic [31:0] pnd,
                      input logic exp_rdy, input logic exp_wre, input logic [1:0] exp_cause);
    @(posedge clock);
    #1;
    reset = rst; in_valid = v; in_fu = fu; in_rs = rs; in_rt = rt; in_rd = rd;
    in_wr = wr; pnd_sgn = pnd;
    if (v && exp_rdy) exp_q.push_back({fu, rs, rt, rd});
    @(negedge clock);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("sb_wre", {31'd0, sb_wre}, {31'd0, exp_wre});
    check("stall_cause", {30'd0, stall_cause}, {30'd0, prev_cause});
    if (!exp_wre) check("sb_addr_tag", {25'd0, sb_func_uni, sb_reg_addr}, {25'd0, fu, rd});
    if (rst) check("reset_issue_quiet",
                   {15'd0, issue_valid, issue_fu, issue_rs, issue_rt, issue_rd}, 32'd0);
    prev_cause = exp_cause;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_fu = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_wr = 1'b0; pnd_sgn = '0;
    // Reset held 3 cycles with a valid request present
    for (int i = 0; i < 3; i++) step(1, 1, 2'd0, 5'd2, 5'd3, 5'd1, 1, 0, 0, 1, 0);
    // A1: first cycle out of reset issues
    step(0, 1, 2'd0, 5'd2, 5'd3, 5'd1, 1, 32'd0, 1, 0, 0);
    // A2: FU1 writer rd=5
    step(0, 1, 2'd1, 5'd1, 5'd0, 5'd5, 1, 32'd0, 1, 0, 0);
    // A3/A4: RAW on r5, then release (non-writer, so no strobe)
    step(0, 1, 2'd2, 5'd5, 5'd0, 5'd6, 0, 32'h20, 0, 1, 1);
    step(0, 1, 2'd2, 5'd5, 5'd0, 5'd6, 0, 32'd0, 1, 1, 0);
    // A5: r0 source pending and r0 destination: issue without strobe
    step(0, 1, 2'd0, 5'd0, 5'd0, 5'd0, 1, 32'h1, 1, 1, 0);
    // A6/A7: WAW on r7, then release
    step(0, 1, 2'd0, 5'd4, 5'd4, 5'd7, 1, 32'h80, 0, 1, 1);
    step(0, 1, 2'd0, 5'd4, 5'd4, 5'd7, 1, 32'd0, 1, 0, 0);
    // A8: FU3 issue at t; t+1..t+4 busy; t+5 accepted
    step(0, 1, 2'd3, 5'd9, 5'd10, 5'd8, 0, 32'd0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2'd3, 5'd1, 5'd2, 5'd11, 0, 32'd0, 0, 1, 2);
    step(0, 1, 2'd3, 5'd1, 5'd2, 5'd11, 0, 32'd0, 1, 1, 0);
    // A14-A16: FU1 writer, then FU2 writer collides on the bus, issues one cycle later
    step(0, 1, 2'd1, 5'd3, 5'd4, 5'd12, 1, 32'd0, 1, 0, 0);
    step(0, 1, 2'd2, 5'd3, 5'd4, 5'd13, 1, 32'd0, 0, 1, 3);
    step(0, 1, 2'd2, 5'd3, 5'd4, 5'd13, 1, 32'd0, 1, 0, 0);
    // A17: data hazard outranks FU3 busy; A18 issues once both clear
    step(0, 1, 2'd3, 5'd13, 5'd0, 5'd14, 1, 32'h2000, 0, 1, 1);
    step(0, 1, 2'd3, 5'd13, 5'd0, 5'd14, 1, 32'd0, 1, 0, 0);
    // A19: idle so the A18 issue pulse is seen before reset
    step(0, 0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 1, 1, 0);
    // Mid-operation reset drops the FU3 occupancy left by A18
    step(1, 1, 2'd3, 5'd1, 5'd2, 5'd15, 1, 32'd0, 0, 1, 0);
    step(0, 1, 2'd3, 5'd1, 5'd2, 5'd15, 1, 32'd0, 1, 0, 0);
    // Ten stalled cycles on a RAW hazard
    for (int i = 0; i < 10; i++) step(0, 1, 2'd0, 5'd20, 5'd0, 5'd3, 1, 32'h0010_0000, 0, 1, 1);
    step(0, 0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 1, 1, 0);
`ifdef ISSUE_STALL_CNT_EN
    check("stall_cnt", {16'd0, stall_cnt}, 32'd10);
`else
    check("stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    step(0, 0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 1, 1, 0);
    step(0, 0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 32'd0, 1, 1, 0);
    check("issue_queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- In-order, single-issue controller between decode and the four functional units (FU0–FU3).
- Holds the decoded instruction until RAW/WAW hazards against the scoreboard pending vector clear, the target FU is free, and the writeback-bus slot is free.
- On issue, it strobes the scoreboard to mark the destination register pending and forwards the instruction to the FU one cycle later.

Parameters:
- LAT0, 1, FU0 (ALU) latency in cycles, pipelined
- LAT1, 3, FU1 (MUL) latency, pipelined
- LAT2, 2, FU2 (MEM) latency, pipelined
- LAT3, 5, FU3 (DIV) latency, non-pipelined
- WB_DEPTH, 8, writeback reservation window width; all LATx must lie in 1..WB_DEPTH-1

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid=1
- in_rs  in  5  source register A
- in_rt  in  5  source register B
- in_rd  in  5  destination register
- in_wr  in  1  instruction writes in_rd
- in_fu  in  2  target functional unit
- pnd_sgn  in  32  scoreboard pending vector
- sb_wre  out  1  scoreboard write strobe, active-low
- sb_reg_addr  out  5  register to mark pending
- sb_func_uni  out  2  FU tag written to the scoreboard
- issue_valid  out  1  registered issue pulse to the FUs
- issue_fu  out  2  registered FU select
- issue_rs, issue_rt, issue_rd  out  5 each  registered operands
- stall_cause  out  2  0=none, 1=data hazard, 2=FU busy, 3=writeback conflict
- stall_cnt  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset: the synchronous active-high reset is sampled on posedge clock.
  - While reset=1: in_ready=0, sb_wre=1, issue_valid=0, issue_* =0, stall_cause=0.
  - Reset clears wb_resv, fu3_cnt and stall_cnt.
  - Reset mid-operation drops all reservations; the top level resets the scoreboard together with this block.
- Hazards (combinational, current cycle):
  - raw = (in_rs!=0 & pnd_sgn[in_rs]) | (in_rt!=0 & pnd_sgn[in_rt]).
  - waw = in_wr & in_rd!=0 & pnd_sgn[in_rd].
  - Register 0 never causes a hazard.
- Structural hazard: fu_busy = (in_fu==3) & (fu3_cnt!=0).
- Writeback hazard: wb_busy = in_wr & wb_resv[LAT(in_fu)]; bit k of wb_resv means the bus is used k cycles from now.
- in_ready = !reset & !raw & !waw & !fu_busy & !wb_busy. It is combinational and independent of in_valid.
- stall_cause (only when in_valid & !in_ready):
  - priority data(1) > FU busy(2) > writeback(3); otherwise 0.
  - Registered, so it reflects the previous cycle.
- Issue condition: issue = in_valid & in_ready.
- Scoreboard strobe (combinational, same cycle as issue):
  - sb_wre = !(issue & in_wr & in_rd!=0).
  - sb_reg_addr=in_rd, sb_func_uni=in_fu.
  - Pending is therefore visible on pnd_sgn from the next cycle, so a back-to-back dependent instruction stalls.
- Next edge:
  - issue_valid<=issue; issue_* <= inputs when issue, otherwise held.
  - wb_resv <= (wb_resv>>1) | (issue&in_wr ? 1<<(LAT-1) : 0).
  - fu3_cnt:
    - Loads LAT3-1 on an FU3 issue.
    - Otherwise decrements when nonzero.
    - FU3 accepts again exactly LAT3 cycles after its previous issue.
- Boundaries:
  - wb_resv bit 0 shifts out; there is no wrap.
  - Back-to-back FU0 issues are always allowed unless a writeback collides.
  - An instruction with in_wr=0 never reserves the bus and never strobes the scoreboard.
- Throughput: at most 1 issue per cycle.
- Inputs must stay stable while in_valid & !in_ready.

Optional Feature:
- Macro: ISSUE_STALL_CNT_EN.
- When defined:
  - stall_cnt is a 16-bit counter incremented every cycle with in_valid & !in_ready.
  - It saturates at 16'hFFFF and clears on reset.
- When undefined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset held 3 cycles with in_valid=1 -> in_ready=0, sb_wre=1, issue_valid=0; first cycle after reset releases, in_ready=1 and issue proceeds.
- Data hazard stall and release:
  - Stimulus: issue FU1 rd=5; next cycle in_rs=5 with pnd_sgn[5]=1.
  - Response: in_ready=0, stall_cause=1 one cycle later.
  - Stimulus: pnd_sgn[5] drops.
  - Response: issue in that cycle, sb_wre=0 only if in_wr.
- r0 handling: in_rs=0 with pnd_sgn[0]=1 -> no stall; in_wr=1, in_rd=0 -> sb_wre stays 1 and issue_valid=1.
- FU3 occupancy: issue FU3 at cycle t -> FU3 requests rejected at t+1..t+4 with stall_cause=2; accepted at t+5.
- Writeback conflict:
  - Stimulus: FU1 (LAT 3) writer at cycle t, then FU2 (LAT 2) writer at t+1.
  - Response: wb_busy=1, stall_cause=3; FU2 writer issues at t+2.
- Stall counter: ISSUE_STALL_CNT_EN defined, 10 stalled cycles -> stall_cnt=10; undefined -> stall_cnt=0.
